// File: rtl/req_priority_encoder_8to3_pkg.sv
// Purpose: shared sizes and FSM state codes for the request priority encoder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package req_priority_encoder_8to3_pkg;

    // Number of request lines and width of the granted index (log2 of N).
    localparam int N     = 8;
    localparam int W_IDX = 3;

    // Grant FSM state codes.
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_GRANT = 1'b1;

endpackage

// File: rtl/req_priority_encoder_8to3_prio_enc.sv
// Purpose: combinational fixed-priority encoder, highest set bit wins.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the output follows the input vector.
module prio_enc_8to3
    import req_priority_encoder_8to3_pkg::*;
(
    input  logic [N-1:0]     req,
    output logic [W_IDX-1:0] idx,
    output logic             any_set
);

    // Ascending scan so the last match, the highest index, is what remains.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = W_IDX'(i);
            end
        end
    end

    assign any_set = |req;

endmodule

// File: rtl/req_priority_encoder_8to3.sv
// Purpose: sticky pending-request register with highest-index grant held until ACK.
// Latency: W->PEND 1 edge, PEND->grant (Z) 1 more edge; ACK drops Z on the same edge.
// Backpressure: grant is frozen while ACK is low; new requests accumulate in PEND.
module req_priority_encoder_8to3
    import req_priority_encoder_8to3_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             EN,
    input  logic [N-1:0]     W,
    input  logic             ACK,
    output logic [W_IDX-1:0] Y,
    output logic             Z,
    output logic [N-1:0]     PEND
);

    state_t           state;
    logic [N-1:0]     pend;
    logic [W_IDX-1:0] y_q;
    logic             z_q;

    logic [W_IDX-1:0] enc_idx;
    logic             enc_any;
    logic             ack_fire;
    logic [N-1:0]     clr;
    logic [N-1:0]     set;
    logic [N-1:0]     pend_nxt;

    // The encoder always looks at the registered pending set, never at W.
    prio_enc_8to3 u_prio_enc (
        .req     (pend),
        .idx     (enc_idx),
        .any_set (enc_any)
    );

    // Clear is only honoured while a grant is outstanding; the set term is
    // OR-ed in last so a request arriving on the acknowledged bit survives.
    always_comb begin
        ack_fire = (state == ST_GRANT) && ACK;
        clr      = ack_fire ? (N'(1) << y_q) : '0;
        set      = EN ? W : '0;
        pend_nxt = (pend & ~clr) | set;
    end

    // Pending register, grant FSM and registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pend  <= '0;
            y_q   <= '0;
            z_q   <= 1'b0;
            state <= ST_IDLE;
        end else begin
            pend <= pend_nxt;
            case (state)
                ST_IDLE: begin
                    // Y keeps its last value until a new grant is issued.
                    if (enc_any) begin
                        y_q   <= enc_idx;
                        z_q   <= 1'b1;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // No preemption: Y stays frozen until the consumer acks.
                    if (ACK) begin
                        z_q   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    z_q   <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Y    = y_q;
    assign Z    = z_q;
    assign PEND = pend;

endmodule

// File: doc/req_priority_encoder_8to3.md
Name: req_priority_encoder_8to3

Overview:
- Sequential counterpart to the 3-to-8 decoder: collects up to 8 one-hot or multi-hot request lines into a sticky pending register.
- Grants the highest-index pending request as a 3-bit code with a valid flag.
- Holds each grant stable until the consumer acknowledges it, then clears that request.
- Sits between lab-board request sources (buttons, decoder outputs) and a consumer that needs a binary index.

Parameters:
- N, 8, number of request lines.
- W_IDX, 3, width of the granted index; must equal log2(N).

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- EN  input  1  request capture enable; when 0, W is ignored.
- W  input  N  request lines, sampled every clock edge; W[7] has the highest priority.
- ACK  input  1  consumer acknowledge of the current grant.
- Y  output  W_IDX  granted index, registered.
- Z  output  1  grant valid, registered.
- PEND  output  N  pending-request register, for observation.

Behaviour:
- Reset (sampled at a Clock edge with Reset=1): PEND=0, Y=0, Z=0, state=IDLE.
  - Reset overrides every other input.
  - Reset during GRANT drops the grant with no ACK needed.
- Capture, every edge while EN=1: PEND <= (PEND & ~clr) | W.
  - clr is one-hot at Y when the grant is being acknowledged this edge, else 0.
  - A set from W wins over a clear on the same bit, so no request is lost.
- EN=0: PEND only loses bits through acknowledged clears; the grant flow continues.
- FSM, 2 states:
  - IDLE: Z=0. If PEND!=0 at the edge, Y <= index of the highest set bit of PEND, Z <= 1, go to GRANT. Otherwise stay; Y keeps its last value.
  - GRANT: Z=1, Y frozen. No preemption: a newly arriving higher-index request waits.
    - ACK=1: clear PEND[Y] (subject to the set-wins rule), Z <= 0, go to IDLE.
    - ACK=0: stay.
- ACK while in IDLE is ignored.
- Latency:
  - W asserted before edge k → PEND bit set after edge k → Z=1 after edge k+1, so 2 edges from an idle start.
  - ACK at edge j → Z=0 after edge j. The next grant, if any, has Z=1 after edge j+1.
  - There is always exactly one Z=0 cycle between consecutive grants.
- Priority is a strict fixed order, highest index first (7 > ... > 0). It is not round-robin.
- W may stay high across many cycles. The bit re-sets PEND every EN=1 edge, so a held request is re-granted after its ACK.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package:
  - State enum {IDLE, GRANT}.
  - Constants N=8 and W_IDX=3.
- One sub-module, prio_enc_8to3: purely combinational.
  - Input: N-bit vector.
  - Outputs: W_IDX-bit index of the highest set bit, and any_set.
  - It is instantiated once on PEND.
- The FSM, PEND register and output registers live in the top module.

Test Plan:
- Reset then idle: Reset=1 for 2 edges with W=8'hFF, EN=1 → PEND=0, Z=0, Y=0. Release reset → PEND=8'hFF after 1 edge, then Z=1, Y=7.
- Single request: EN=1, W=8'b0000_0100 pulsed 1 cycle → Z=1, Y=2 on the 2nd edge. Hold ACK=0 for 5 cycles → Y stays 2. ACK=1 → Z=0, PEND=0.
- Multi-hot drain: W=8'b1010_0010 pulsed, ACK held 1 → grants Y=7, then 5, then 1. Each grant is Z=1 for 1 cycle with one Z=0 cycle between. Ends with PEND=0.
- No preemption: grant Y=3 active, then W=8'h80 pulsed → Y stays 3 and PEND=8'h88. ACK → next grant is Y=7.
- Set-wins collision: in GRANT with Y=4, ACK=1 and W[4]=1 on the same edge with EN=1 → PEND[4] stays 1 and Z=0. The next edge re-grants Y=4.
- EN gating / reset mid-grant: EN=0, W=8'hFF → PEND unchanged. During GRANT, assert Reset for 1 edge → Z=0, PEND=0, state IDLE.
